// File: rtl/move_backtracker.sv
`default_nettype none
// ============================================================================
//  Module   : move_backtracker
//  Purpose  : Maze-walker position tracker with a LIFO move history. Forward
//             moves (+/-STEP on x or y) are applied and recorded; undo pops
//             one move and applies its inverse, and rewind pops every
//             recorded move automatically, one per cycle.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             init, x0, y0       - load start position, clear history
//             push, dir          - apply and record move dir
//                                  (dir[1]: 0=x 1=y, dir[0]: 0=-STEP 1=+STEP)
//             undo, rewind       - pop one move / start full rewind
//             x, y, sign         - position, bit SIZE of last add/sub result
//             count, empty, full - history occupancy
//             busy, done, ovf    - rewind active, rewind-end pulse,
//                                  dropped-push pulse
//  Revision : 1.0  initial release
// ============================================================================
module move_backtracker #(
    parameter int SIZE  = 5,
    parameter int STEP  = 5,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init,
    input  logic [SIZE-1:0]          x0,
    input  logic [SIZE-1:0]          y0,
    input  logic                     push,
    input  logic [1:0]               dir,
    input  logic                     undo,
    input  logic                     rewind,
    output logic [SIZE-1:0]          x,
    output logic [SIZE-1:0]          y,
    output logic                     sign,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     busy,
    output logic                     done,
    output logic                     ovf
);

    localparam int                c_AW   = $clog2(DEPTH);
    localparam logic [SIZE:0]     c_STEP = (SIZE+1)'(STEP);
    localparam logic [c_AW:0]     c_FULL = (c_AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REWIND = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            r_state_q, w_state_d;
    logic [SIZE-1:0]   r_x_q, w_x_d;
    logic [SIZE-1:0]   r_y_q, w_y_d;
    logic              r_sign_q, w_sign_d;
    logic [c_AW:0]     r_count_q, w_count_d;
    logic              r_empty_q, w_empty_d;
    logic              r_full_q, w_full_d;
    logic              r_busy_q, w_busy_d;
    logic              r_done_q, w_done_d;
    logic              r_ovf_q, w_ovf_d;

    // History storage; contents are never reset, only count qualifies them.
    logic [1:0]        r_stack_q [DEPTH];

    logic              w_load;
    logic              w_push_en;
    logic              w_pop_en;
    logic [c_AW-1:0]   w_top_idx;
    logic [1:0]        w_top;
    logic [1:0]        w_move_dir;
    logic [SIZE-1:0]   w_src;
    logic [SIZE:0]     w_res;

    assign w_top_idx = c_AW'(r_count_q - 1'b1);
    assign w_top     = r_stack_q[w_top_idx];

    // ------------------------------------------------------------------
    // Control: decide which single action happens this cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        w_load    = 1'b0;
        w_push_en = 1'b0;
        w_pop_en  = 1'b0;
        w_ovf_d   = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (init) begin
                    w_load = 1'b1;
                end else if (rewind) begin
                    w_state_d = S_REWIND;
                end else if (undo) begin
                    w_pop_en = !r_empty_q;
                end else if (push) begin
                    if (r_full_q) begin
                        w_ovf_d = 1'b1;
                    end else begin
                        w_push_en = 1'b1;
                    end
                end
            end
            S_REWIND: begin
                if (init) begin
                    w_load    = 1'b1;
                    w_state_d = S_IDLE;
                end else if (!r_empty_q) begin
                    w_pop_en = 1'b1;
                end else begin
                    w_state_d = S_DONE;
                end
            end
            S_DONE:  w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    // A pop applies the inverse of the stored move: same axis, flipped op.
    assign w_move_dir = w_pop_en ? {w_top[1], ~w_top[0]} : dir;
    assign w_src      = w_move_dir[1] ? r_y_q : r_x_q;
    // Zero-extended SIZE+1 bit add/sub; the low SIZE bits wrap modulo
    // 2^SIZE, so an inverse move always restores the exact coordinate.
    assign w_res      = w_move_dir[0] ? ({1'b0, w_src} + c_STEP)
                                      : ({1'b0, w_src} - c_STEP);

    // ------------------------------------------------------------------
    // Datapath next values.
    // ------------------------------------------------------------------
    always_comb begin
        w_x_d     = r_x_q;
        w_y_d     = r_y_q;
        w_sign_d  = r_sign_q;
        w_count_d = r_count_q;
        if (w_load) begin
            w_x_d     = x0;
            w_y_d     = y0;
            w_sign_d  = 1'b0;
            w_count_d = '0;
        end else if (w_push_en || w_pop_en) begin
            if (w_move_dir[1]) begin
                w_y_d = w_res[SIZE-1:0];
            end else begin
                w_x_d = w_res[SIZE-1:0];
            end
            w_sign_d  = w_res[SIZE];
            w_count_d = w_push_en ? r_count_q + 1'b1 : r_count_q - 1'b1;
        end
        w_empty_d = (w_count_d == '0);
        w_full_d  = (w_count_d == c_FULL);
        w_busy_d  = (w_state_d == S_REWIND);
        w_done_d  = (w_state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_x_q     <= '0;
            r_y_q     <= '0;
            r_sign_q  <= 1'b0;
            r_count_q <= '0;
            r_empty_q <= 1'b1;
            r_full_q  <= 1'b0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
            r_ovf_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_x_q     <= w_x_d;
            r_y_q     <= w_y_d;
            r_sign_q  <= w_sign_d;
            r_count_q <= w_count_d;
            r_empty_q <= w_empty_d;
            r_full_q  <= w_full_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
            r_ovf_q   <= w_ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_en) begin
            r_stack_q[r_count_q[c_AW-1:0]] <= dir;
        end
    end

    assign x     = r_x_q;
    assign y     = r_y_q;
    assign sign  = r_sign_q;
    assign count = r_count_q;
    assign empty = r_empty_q;
    assign full  = r_full_q;
    assign busy  = r_busy_q;
    assign done  = r_done_q;
    assign ovf   = r_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_move_backtracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_move_backtracker
//  Purpose  : Self-checking bench for move_backtracker. A queue-based
//             behavioural model tracks the expected position and history;
//             every cycle all outputs are compared against it, and literal
//             expectations pin key points of the scenario.
//  Revision : 1.0  initial release
// ============================================================================
module tb_move_backtracker;

    localparam int SIZE  = 5;
    localparam int STEP  = 5;
    localparam int DEPTH = 16;
    localparam int MOD   = 1 << SIZE;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              init = 1'b0;
    logic [SIZE-1:0]   x0 = '0;
    logic [SIZE-1:0]   y0 = '0;
    logic              push = 1'b0;
    logic [1:0]        dir = 2'b00;
    logic              undo = 1'b0;
    logic              rewind = 1'b0;
    logic [SIZE-1:0]   x, y;
    logic              sign;
    logic [$clog2(DEPTH):0] count;
    logic              empty, full, busy, done, ovf;

    move_backtracker #(.SIZE(SIZE), .STEP(STEP), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .init(init), .x0(x0), .y0(y0),
        .push(push), .dir(dir), .undo(undo), .rewind(rewind),
        .x(x), .y(y), .sign(sign), .count(count), .empty(empty),
        .full(full), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    int         mx, my, msign;
    int         mmode;          // 0 idle, 1 rewinding, 2 done
    int         movf;
    logic [1:0] mq[$];

    function automatic void chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Apply one move to the model coordinate using plain integer arithmetic.
    function automatic void m_apply(logic [1:0] d);
        int c, r;
        c = d[1] ? my : mx;
        r = d[0] ? c + STEP : c - STEP;
        if (r < 0) r += 2 * MOD;
        msign = (r / MOD) % 2;
        if (d[1]) my = r % MOD; else mx = r % MOD;
    endfunction

    function automatic void m_load();
        mx = int'(x0);
        my = int'(y0);
        msign = 0;
        mq.delete();
    endfunction

    function automatic void m_pop();
        logic [1:0] t;
        t = mq.pop_back();
        m_apply({t[1], ~t[0]});
    endfunction

    function automatic void model_step();
        movf = 0;
        if (rst) begin
            mx = 0; my = 0; msign = 0; mmode = 0; mq.delete();
        end else if (mmode == 0) begin
            if (init) m_load();
            else if (rewind) mmode = 1;
            else if (undo) begin
                if (mq.size() > 0) m_pop();
            end else if (push) begin
                if (mq.size() == DEPTH) movf = 1;
                else begin
                    m_apply(dir);
                    mq.push_back(dir);
                end
            end
        end else if (mmode == 1) begin
            if (init) begin
                m_load();
                mmode = 0;
            end else if (mq.size() > 0) m_pop();
            else mmode = 2;
        end else begin
            mmode = 0;
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("x", int'(x), mx);
        chk("y", int'(y), my);
        chk("sign", int'(sign), msign);
        chk("count", int'(count), mq.size());
        chk("empty", int'(empty), int'(mq.size() == 0));
        chk("full", int'(full), int'(mq.size() == DEPTH));
        chk("busy", int'(busy), int'(mmode == 1));
        chk("done", int'(done), int'(mmode == 2));
        chk("ovf", int'(ovf), movf);
    endtask

    task automatic do_init(int ix, int iy);
        init = 1'b1; x0 = SIZE'(ix); y0 = SIZE'(iy);
        tick();
        init = 1'b0;
    endtask

    task automatic do_push(logic [1:0] d);
        push = 1'b1; dir = d;
        tick();
        push = 1'b0;
    endtask

    task automatic do_undo();
        undo = 1'b1;
        tick();
        undo = 1'b0;
    endtask

    int busy_cnt, done_cnt;

    initial begin
        mx = 0; my = 0; msign = 0; mmode = 0; movf = 0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_x", int'(x), 0);
        chk("rst_empty", int'(empty), 1);

        // Basic moves
        do_init(10, 20);
        do_push(2'b01);
        chk("lit_x15", int'(x), 15);
        do_push(2'b10);
        chk("lit_y15", int'(y), 15);
        chk("lit_cnt2", int'(count), 2);
        chk("lit_sign0", int'(sign), 0);
        do_undo();
        chk("lit_y20", int'(y), 20);
        chk("lit_cnt1", int'(count), 1);
        do_undo();
        chk("lit_x10", int'(x), 10);
        chk("lit_empty", int'(empty), 1);
        do_undo();
        chk("lit_undo_empty_x", int'(x), 10);
        chk("lit_undo_empty_cnt", int'(count), 0);

        // Underflow / wrap
        do_init(3, 20);
        do_push(2'b00);
        chk("lit_wrap_x30", int'(x), 30);
        chk("lit_wrap_sign1", int'(sign), 1);
        do_undo();
        chk("lit_unwrap_x3", int'(x), 3);
        chk("lit_unwrap_sign1", int'(sign), 1);

        // Full stack
        do_init(10, 20);
        for (int i = 0; i < 16; i++) do_push(2'(i % 4));
        chk("lit_full", int'(full), 1);
        do_push(2'b01);
        chk("lit_ovf", int'(ovf), 1);
        chk("lit_full_cnt16", int'(count), 16);
        tick();
        chk("lit_ovf_pulse", int'(ovf), 0);

        // Rewind of 3 with push/undo during busy
        do_init(10, 20);
        do_push(2'b01);
        do_push(2'b11);
        do_push(2'b00);
        busy_cnt = 0; done_cnt = 0;
        rewind = 1'b1;
        tick();
        rewind = 1'b0;
        busy_cnt += int'(busy); done_cnt += int'(done);
        push = 1'b1; undo = 1'b1; dir = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            busy_cnt += int'(busy); done_cnt += int'(done);
        end
        push = 1'b0; undo = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            busy_cnt += int'(busy); done_cnt += int'(done);
        end
        chk("lit_rw_busy4", busy_cnt, 4);
        chk("lit_rw_done1", done_cnt, 1);
        chk("lit_rw_x10", int'(x), 10);
        chk("lit_rw_y20", int'(y), 20);
        chk("lit_rw_empty", int'(empty), 1);

        // Rewind with empty stack
        busy_cnt = 0;
        rewind = 1'b1;
        tick();
        rewind = 1'b0;
        busy_cnt += int'(busy);
        tick();
        chk("lit_rw0_done", int'(done), 1);
        chk("lit_rw0_busy1", busy_cnt + int'(busy), 1);
        tick();

        // Reset mid-rewind
        do_init(10, 20);
        for (int i = 0; i < 4; i++) do_push(2'b01);
        rewind = 1'b1;
        tick();
        rewind = 1'b0;
        tick();
        tick();
        chk("lit_mid_cnt2", int'(count), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("lit_rst_busy", int'(busy), 0);
        chk("lit_rst_x", int'(x), 0);
        chk("lit_rst_cnt", int'(count), 0);
        tick();

        // Init aborts rewind
        do_init(10, 20);
        for (int i = 0; i < 3; i++) do_push(2'b11);
        rewind = 1'b1;
        tick();
        rewind = 1'b0;
        tick();
        do_init(7, 9);
        chk("lit_abort_x7", int'(x), 7);
        chk("lit_abort_y9", int'(y), 9);
        chk("lit_abort_cnt0", int'(count), 0);
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            done_cnt += int'(done);
        end
        chk("lit_abort_nodone", done_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
